// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-port RAM between the CPU load/store unit
//   and the VGA pixel fetcher. VGA wins by fixed priority. A starvation guard
//   forces a CPU slot after MAX_STREAK back-to-back VGA wins while the CPU is
//   waiting. The winning command is registered onto the RAM port, and read
//   data is routed back to whichever requester issued the read.
//
// Ports
//   CLOCK_50    in   system clock, all state on posedge
//   reset       in   synchronous, active-high
//   cpu_req     in   CPU request, held until cpu_ready
//   cpu_we      in   1 = store, 0 = load
//   cpu_addr    in   CPU word address
//   cpu_wdata   in   store data
//   cpu_ready   out  CPU request accepted this cycle (combinational)
//   cpu_rvalid  out  load data valid on cpu_rdata (single-cycle pulse)
//   cpu_rdata   out  load data
//   vga_req     in   pixel-word read request, held until vga_ready
//   vga_addr    in   pixel word address
//   vga_ready   out  VGA request accepted this cycle (combinational)
//   vga_rvalid  out  pixel data valid (single-cycle pulse)
//   vga_rdata   out  pixel data
//   mem_en      out  RAM enable (registered)
//   mem_we      out  RAM write enable (registered)
//   mem_addr    out  RAM address (registered)
//   mem_wdata   out  RAM write data (registered)
//   mem_rdata   in   RAM read data, valid the cycle after mem_en & !mem_we

module mem_port_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_ready,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_VGA = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  logic [SW-1:0] streak;
  logic          force_cpu;
  logic          cpu_xfer;
  logic          vga_xfer;
  logic          rd_xfer;
  tag_t          tag_s1;
  tag_t          tag_s2;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vga_rdata_q;

  // Grants are gated by reset so nothing can be accepted (and later return
  // data) while the block is being reset.
  always_comb begin
    force_cpu = cpu_req && (streak == STREAK_MAX);
    vga_ready = !reset && vga_req && !force_cpu;
    cpu_ready = !reset && cpu_req && (force_cpu || !vga_req);
  end

  assign cpu_xfer = cpu_req && cpu_ready;
  assign vga_xfer = vga_req && vga_ready;
  assign rd_xfer  = vga_xfer || (cpu_xfer && !cpu_we);

  // Address/data only follow the winner; while idle they keep their last
  // value since mem_en=0 makes them don't-care for the RAM.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= cpu_xfer || vga_xfer;
      mem_we <= cpu_xfer && cpu_we;
      if (cpu_xfer) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vga_xfer) begin
        mem_addr  <= vga_addr;
      end
    end
  end

  // Counts VGA wins that happened while the CPU was left waiting. Any CPU
  // win, or the CPU going quiet, restarts the count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      streak <= '0;
    end else if (cpu_xfer || !cpu_req) begin
      streak <= '0;
    end else if (vga_xfer && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

  // Stage 1 lines up with the mem_* registers, stage 2 with the RAM output.
  // Clearing both on reset drops any read still in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tag_s1 <= '{valid: 1'b0, owner: OWNER_CPU};
      tag_s2 <= '{valid: 1'b0, owner: OWNER_CPU};
    end else begin
      tag_s1.valid <= rd_xfer;
      tag_s1.owner <= vga_xfer ? OWNER_VGA : OWNER_CPU;
      tag_s2       <= tag_s1;
    end
  end

  assign cpu_rvalid = tag_s2.valid && (tag_s2.owner == OWNER_CPU);
  assign vga_rvalid = tag_s2.valid && (tag_s2.owner == OWNER_VGA);

  // The RAM output is itself registered, so it is passed straight through in
  // the valid cycle; the holding registers keep each requester's last word
  // afterwards so one owner never sees the other's data.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (vga_rvalid) vga_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign vga_rdata = vga_rvalid ? mem_rdata : vga_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
//   RAM word at address a is preloaded with 0xC0DE0000 | a.

module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          CLOCK_50;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ready;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int check_count = 0;
  int pass_count  = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_ready  (vga_ready),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous single-port RAM: write on enable+we, registered read.
  always @(posedge CLOCK_50) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen on the
  // following falling edge.
  task automatic next_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic sample();
    @(negedge CLOCK_50);
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    vga_req = 1'b0;
    cpu_we  = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    cpu_req = 1'b1;
    vga_req = 1'b1;
    cpu_addr = 12'h001;
    vga_addr = 12'h002;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      sample();
      check_count++;
      if ({cpu_ready, vga_ready, mem_en, cpu_rvalid, vga_rvalid} !== 5'b0)
        $display("[TB] FAIL reset_outputs cyc%0d: got rdy=%b%b en=%b rv=%b%b, want all 0",
                 c, cpu_ready, vga_ready, mem_en, cpu_rvalid, vga_rvalid);
      else pass_count++;
    end
    check_count++;
    if ({mem_we, mem_addr, mem_wdata} !== '0)
      $display("[TB] FAIL reset_mem_regs: got we=%b addr=%h wdata=%h, want 0", mem_we, mem_addr, mem_wdata);
    else pass_count++;
    next_cycle();
    reset   = 1'b0;
    cpu_req = 1'b0;
    vga_req = 1'b0;
    sample();
    check_count++;
    if ({cpu_ready, vga_ready, mem_en} !== 3'b0)
      $display("[TB] FAIL reset_release_idle: got rdy=%b%b en=%b, want 000", cpu_ready, vga_ready, mem_en);
    else pass_count++;
  endtask

  task automatic test_cpu_only();
    idle(3);
    // store
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
    sample();
    check_count++;
    if (cpu_ready !== 1'b1 || vga_ready !== 1'b0)
      $display("[TB] FAIL cpu_store_ready: got cpu=%b vga=%b, want 1 0", cpu_ready, vga_ready);
    else pass_count++;
    // load of the same address accepted the very next cycle
    next_cycle();
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    sample();
    check_count++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 12'h010 || mem_wdata !== 32'hDEADBEEF)
      $display("[TB] FAIL cpu_store_cmd: got en=%b we=%b addr=%h wd=%h, want 1 1 010 deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    else pass_count++;
    check_count++;
    if (cpu_ready !== 1'b1)
      $display("[TB] FAIL cpu_load_ready: got %b, want 1", cpu_ready);
    else pass_count++;
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check_count++;
    if ({mem_en, mem_we, cpu_rvalid} !== 3'b100)
      $display("[TB] FAIL cpu_load_cmd: got en=%b we=%b rvalid=%b, want 1 0 0", mem_en, mem_we, cpu_rvalid);
    else pass_count++;
    next_cycle();
    sample();
    check_count++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || vga_rvalid !== 1'b0)
      $display("[TB] FAIL cpu_load_data: got rv=%b data=%h vrv=%b, want 1 deadbeef 0",
               cpu_rvalid, cpu_rdata, vga_rvalid);
    else pass_count++;
    next_cycle();
    sample();
    check_count++;
    if (cpu_rvalid !== 1'b0 || mem_en !== 1'b0)
      $display("[TB] FAIL cpu_rvalid_pulse: got rv=%b en=%b, want 0 0", cpu_rvalid, mem_en);
    else pass_count++;
    // CPU alone is granted every cycle
    idle(1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h011;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      sample();
      check_count++;
      if (cpu_ready !== 1'b1)
        $display("[TB] FAIL cpu_alone_grant cyc%0d: got %b, want 1", c, cpu_ready);
      else pass_count++;
    end
  endtask

  task automatic test_contention();
    logic exp_v [12];
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    idle(3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
    vga_req = 1'b1; vga_addr = 12'h020;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      sample();
      check_count++;
      if (vga_ready !== exp_v[c] || cpu_ready !== !exp_v[c])
        $display("[TB] FAIL contention_grant cyc%0d: got vga=%b cpu=%b, want vga=%b cpu=%b",
                 c, vga_ready, cpu_ready, exp_v[c], !exp_v[c]);
      else pass_count++;
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    idle(2);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) next_cycle();
      if (c < 8) begin
        vga_req  = 1'b1;
        vga_addr = 12'h100 + 12'(c);
      end else begin
        vga_req = 1'b0;
      end
      sample();
      if (c < 8) begin
        check_count++;
        if (vga_ready !== 1'b1)
          $display("[TB] FAIL b2b_ready cyc%0d: got %b, want 1", c, vga_ready);
        else pass_count++;
      end
      check_count++;
      if (c >= 2 && c < 10) begin
        if (vga_rvalid !== 1'b1 || vga_rdata !== pat(12'h100 + 12'(c - 2)) || cpu_rvalid !== 1'b0)
          $display("[TB] FAIL b2b_data cyc%0d: got rv=%b data=%h, want 1 %h",
                   c, vga_rvalid, vga_rdata, pat(12'h100 + 12'(c - 2)));
        else pass_count++;
      end else begin
        if (vga_rvalid !== 1'b0)
          $display("[TB] FAIL b2b_quiet cyc%0d: got rv=%b, want 0", c, vga_rvalid);
        else pass_count++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic exp_v [5];
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    idle(3);
    // build up a streak of 3 VGA wins, then reset
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h031;
    vga_req = 1'b1; vga_addr = 12'h105;
    next_cycle();
    next_cycle();
    sample();
    check_count++;
    if (vga_ready !== 1'b1)
      $display("[TB] FAIL midrst_accept: got %b, want 1", vga_ready);
    else pass_count++;
    next_cycle();
    reset = 1'b1;
    sample();
    check_count++;
    if (vga_ready !== 1'b0 || cpu_ready !== 1'b0)
      $display("[TB] FAIL midrst_ready: got vga=%b cpu=%b, want 0 0", vga_ready, cpu_ready);
    else pass_count++;
    next_cycle();
    reset = 1'b0;
    // streak must restart at 0: four VGA wins before the forced CPU slot
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      sample();
      if (c < 2) begin
        check_count++;
        if (vga_rvalid !== 1'b0)
          $display("[TB] FAIL midrst_no_rvalid cyc%0d: got %b, want 0", c, vga_rvalid);
        else pass_count++;
      end
      check_count++;
      if (vga_ready !== exp_v[c] || cpu_ready !== !exp_v[c])
        $display("[TB] FAIL midrst_streak cyc%0d: got vga=%b cpu=%b, want vga=%b",
                 c, vga_ready, cpu_ready, exp_v[c]);
      else pass_count++;
    end
    idle(4);
  endtask

  task automatic test_mixed();
    idle(2);
    vga_req = 1'b1; vga_addr = 12'h020;
    sample();
    check_count++;
    if (vga_ready !== 1'b1)
      $display("[TB] FAIL mixed_vga_ready: got %b, want 1", vga_ready);
    else pass_count++;
    next_cycle();
    vga_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
    sample();
    check_count++;
    if (cpu_ready !== 1'b1)
      $display("[TB] FAIL mixed_cpu_ready: got %b, want 1", cpu_ready);
    else pass_count++;
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check_count++;
    if (vga_rvalid !== 1'b1 || vga_rdata !== pat(12'h020) || cpu_rvalid !== 1'b0)
      $display("[TB] FAIL mixed_vga_data: got rv=%b data=%h crv=%b, want 1 %h 0",
               vga_rvalid, vga_rdata, cpu_rvalid, pat(12'h020));
    else pass_count++;
    next_cycle();
    sample();
    check_count++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== pat(12'h030) || vga_rvalid !== 1'b0)
      $display("[TB] FAIL mixed_cpu_data: got rv=%b data=%h vrv=%b, want 1 %h 0",
               cpu_rvalid, cpu_rdata, vga_rvalid, pat(12'h030));
    else pass_count++;
    check_count++;
    if (vga_rdata !== pat(12'h020))
      $display("[TB] FAIL mixed_vga_hold: got %h, want %h", vga_rdata, pat(12'h020));
    else pass_count++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = pat(AW'(i));
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vga_req   = 1'b0;
    vga_addr  = '0;
    test_reset();
    test_cpu_only();
    test_contention();
    test_back_to_back();
    test_reset_midflight();
    test_mixed();
    idle(2);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
